// File: rtl/ecg_frame_buffer_pkg.sv
// Shared state encodings for the ECG frame buffer.
//   bank_st_e : per-bank occupancy (FREE -> FILL -> FULL -> FREE)
//   rd_st_e   : reader handshake (IDLE -> ANNOUNCE -> READ -> IDLE)
package fsm_frame_buffer;
  typedef enum logic [1:0] {B_FREE, B_FILL, B_FULL} bank_st_e;
  typedef enum logic [1:0] {R_IDLE, R_ANNOUNCE, R_READ} rd_st_e;
endpackage

// File: rtl/ecg_frame_buffer_bank_ram.sv
// frame_bank_ram: one frame of sample storage.
//   clk, rst        : clock, async active-low reset (read register only)
//   we/wr_addr/wr_data : synchronous write port
//   re/rd_addr/rd_data : registered read port; rd_data holds when re is low
// The array itself is never reset; only the read register is cleared.
module frame_bank_ram #(
  parameter int DEPTH = 256,
  parameter int W     = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          re,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[wr_addr] <= wr_data;

  always_ff @(posedge clk or negedge rst)
    if (!rst)    rd_data <= '0;
    else if (re) rd_data <= mem[rd_addr];
endmodule

// File: rtl/ecg_frame_buffer.sv
// ecg_frame_buffer: ping-pong frame buffer between an ECG sample stream and
// a transmit handler that reads whole frames by index.
//   clk, rst            : clock, async active-low reset
//   in_valid/in_ready/in_data : sample stream in (ready is combinational)
//   frame_start         : one-cycle pulse, a complete frame is readable
//   rd_addr/rd_data     : sample index in, registered sample out (1 cycle)
//   frame_done          : consumer releases the announced frame
//   frame_sum           : mod-2^N_BITS sum of the announced frame
//                         (only when FRAME_SUM_EN is defined)
module ecg_frame_buffer
  import fsm_frame_buffer::*;
#(
  parameter int N_SAMPLES = 256,
  parameter int N_BITS    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_BITS-1:0]            in_data,
  output logic                         frame_start,
  input  logic [$clog2(N_SAMPLES)-1:0] rd_addr,
  output logic [N_BITS-1:0]            rd_data,
  input  logic                         frame_done
`ifdef FRAME_SUM_EN
  ,
  output logic [N_BITS-1:0]            frame_sum
`endif
);
  localparam int AW = $clog2(N_SAMPLES);

  bank_st_e              bank_st [2];
  rd_st_e                rd_st;
  logic                  wr_bank;   // bank being filled
  logic                  rd_ptr;    // oldest unreleased bank; also the read bank
  logic                  rd_sel;    // bank whose read register drives rd_data
  logic [AW-1:0]         wr_idx;
  logic [1:0][N_BITS-1:0] bank_q;

  logic accept, last, release_frm;

  // Gating with rst keeps ready low while reset is held.
  assign in_ready    = rst && (bank_st[wr_bank] != B_FULL);
  assign accept      = in_valid && in_ready;
  assign last        = accept && (wr_idx == AW'(N_SAMPLES-1));
  assign release_frm = (rd_st == R_READ) && frame_done;

  // Write side and bank occupancy. Completion and release always target
  // different banks (a FULL bank is never the write bank), so both apply.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_st[0] <= B_FREE;
      bank_st[1] <= B_FREE;
      wr_bank    <= 1'b0;
      wr_idx     <= '0;
    end else begin
      if (accept) begin
        wr_idx           <= wr_idx + 1'b1;  // power-of-two depth wraps itself
        bank_st[wr_bank] <= last ? B_FULL : B_FILL;
        if (last) wr_bank <= ~wr_bank;
      end
      if (release_frm) bank_st[rd_ptr] <= B_FREE;
    end
  end

  // Reader FSM. Banks fill alternately, so the oldest FULL bank is always
  // the one after the last released, tracked by rd_ptr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_st       <= R_IDLE;
      rd_ptr      <= 1'b0;
      rd_sel      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (rd_st == R_READ) rd_sel <= rd_ptr;
      case (rd_st)
        R_IDLE:     if (bank_st[rd_ptr] == B_FULL) rd_st <= R_ANNOUNCE;
        R_ANNOUNCE: begin
          frame_start <= 1'b1;
          rd_st       <= R_READ;
        end
        R_READ:     if (frame_done) begin
          rd_st  <= R_IDLE;
          rd_ptr <= ~rd_ptr;
        end
        default:    rd_st <= R_IDLE;
      endcase
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    frame_bank_ram #(.DEPTH(N_SAMPLES), .W(N_BITS), .AW(AW)) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we      (accept && (wr_bank == 1'(b))),
      .wr_addr (wr_idx),
      .wr_data (in_data),
      .re      ((rd_st == R_READ) && (rd_ptr == 1'(b))),
      .rd_addr (rd_addr),
      .rd_data (bank_q[b])
    );
  end

  // rd_sel only moves together with a fresh read, so rd_data holds
  // its last value after the frame is released.
  assign rd_data = bank_q[rd_sel];

`ifdef FRAME_SUM_EN
  logic [1:0][N_BITS-1:0] acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      frame_sum <= '0;
    end else begin
      // Restart at index 0 so a bank reused for a new frame starts clean.
      if (accept)
        acc[wr_bank] <= ((wr_idx == '0) ? '0 : acc[wr_bank]) + in_data;
      if (rd_st == R_ANNOUNCE) frame_sum <= acc[rd_ptr];
    end
  end
`endif
endmodule
